// File: rtl/rr_arb16.sv
// rr_arb16: 16-way round-robin arbiter with registered one-hot grant, done/withdraw release and hold timeout
module rr_arb16 #(
  parameter int HOLD_MAX = 8,
  parameter int TMR_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en,
  input  logic [15:0] req,
  input  logic        done,
  output logic [15:0] gnt,
  output logic [3:0]  gnt_idx,
  output logic        valid,
  output logic        tmo
);
  typedef enum logic [1:0] {IDLE, GRANT, REL} state_t;
  state_t state, state_n;
  logic [3:0] ptr, ptr_n, idx_n, off, win;
  logic [TMR_W-1:0] timer, timer_n;
  logic [15:0] gnt_n, rot;
  logic valid_n, tmo_n, at_max, rel;
  assign rot = 16'({req, req} >> ptr);
  always_comb begin
    off = 4'd0;
    for (int i = 15; i >= 0; i--) off = rot[i] ? i[3:0] : off;
  end
  assign win = ptr + off;
  assign at_max = timer == TMR_W'(HOLD_MAX);
  assign rel = !en || done || !req[gnt_idx] || at_max;
  always_comb begin
    state_n = state;
    ptr_n = ptr;
    idx_n = gnt_idx;
    timer_n = timer;
    gnt_n = gnt;
    valid_n = valid;
    tmo_n = 1'b0;
    case (state)
      IDLE: if (en && |req) begin
        state_n = GRANT;
        idx_n = win;
        gnt_n = 16'd1 << win;
        valid_n = 1'b1;
        timer_n = TMR_W'(1);
      end
      GRANT: if (rel) begin
        state_n = REL;
        gnt_n = 16'd0;
        valid_n = 1'b0;
        ptr_n = gnt_idx + 4'd1;
        tmo_n = en && !done && req[gnt_idx] && at_max;
      end else timer_n = timer + 1'b1;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= 4'd0;
      timer <= '0;
      gnt <= 16'd0;
      gnt_idx <= 4'd0;
      valid <= 1'b0;
      tmo <= 1'b0;
    end else begin
      state <= state_n;
      ptr <= ptr_n;
      timer <= timer_n;
      gnt <= gnt_n;
      gnt_idx <= idx_n;
      valid <= valid_n;
      tmo <= tmo_n;
    end
  end
endmodule

// File: tb/tb_rr_arb16.sv
// tb_rr_arb16: directed vector table plus rotation, timeout and collision sequences for rr_arb16
module tb_rr_arb16;
  logic clk = 1'b0, rst, en, done;
  logic [15:0] req, gnt;
  logic [3:0] gnt_idx;
  logic valid, tmo;
  int n_chk = 0, n_fail = 0;
  typedef struct {
    logic rst, en, done;
    logic [15:0] req, e_gnt;
    logic [3:0] e_idx;
    logic e_valid, e_tmo;
  } vec_t;
  vec_t vecs[$];
  rr_arb16 #(.HOLD_MAX(8), .TMR_W(8)) dut (
    .clk(clk), .rst(rst), .en(en), .req(req), .done(done),
    .gnt(gnt), .gnt_idx(gnt_idx), .valid(valid), .tmo(tmo)
  );
  always #5 clk = ~clk;
  task automatic add(input logic r, e, d, input logic [15:0] q, g, input logic [3:0] x, input logic v, t);
    vec_t w;
    w.rst = r; w.en = e; w.done = d; w.req = q;
    w.e_gnt = g; w.e_idx = x; w.e_valid = v; w.e_tmo = t;
    vecs.push_back(w);
  endtask
  task automatic step(input logic r, e, d, input logic [15:0] q);
    rst = r; en = e; done = d; req = q;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string nm, input logic [15:0] g, input logic [3:0] x, input logic v, t);
    n_chk++;
    if ({gnt, gnt_idx, valid, tmo} !== {g, x, v, t}) begin
      n_fail++;
      $display("FAIL %s: got gnt=%h idx=%0d valid=%b tmo=%b, want gnt=%h idx=%0d valid=%b tmo=%b",
               nm, gnt, gnt_idx, valid, tmo, g, x, v, t);
    end
  endtask
  initial begin
    rst = 1'b1; en = 1'b0; done = 1'b0; req = 16'h0;
    add(1, 1, 0, 16'hFFFF, 16'h0000, 0, 0, 0);
    add(1, 1, 0, 16'hFFFF, 16'h0000, 0, 0, 0);
    add(0, 1, 0, 16'hFFFF, 16'h0001, 0, 1, 0);
    add(1, 1, 0, 16'hFFFF, 16'h0000, 0, 0, 0);
    add(0, 1, 0, 16'h8010, 16'h0010, 4, 1, 0);
    add(0, 1, 1, 16'h8010, 16'h0000, 4, 0, 0);
    add(0, 1, 0, 16'h8010, 16'h0000, 4, 0, 0);
    add(0, 1, 0, 16'h8010, 16'h8000, 15, 1, 0);
    add(0, 1, 1, 16'h8010, 16'h0000, 15, 0, 0);
    add(0, 1, 0, 16'h8010, 16'h0000, 15, 0, 0);
    add(0, 1, 0, 16'h8010, 16'h0010, 4, 1, 0);
    add(0, 1, 1, 16'h8010, 16'h0000, 4, 0, 0);
    add(0, 1, 0, 16'h0008, 16'h0000, 4, 0, 0);
    add(0, 1, 0, 16'h0008, 16'h0008, 3, 1, 0);
    add(0, 1, 0, 16'h0000, 16'h0000, 3, 0, 0);
    add(0, 1, 0, 16'hFFFF, 16'h0000, 3, 0, 0);
    add(0, 1, 0, 16'hFFFF, 16'h0010, 4, 1, 0);
    add(0, 1, 1, 16'hFFFF, 16'h0000, 4, 0, 0);
    add(0, 1, 0, 16'h0008, 16'h0000, 4, 0, 0);
    add(0, 1, 0, 16'h0008, 16'h0008, 3, 1, 0);
    add(0, 0, 0, 16'h0008, 16'h0000, 3, 0, 0);
    add(0, 0, 0, 16'h0008, 16'h0000, 3, 0, 0);
    add(0, 0, 0, 16'h0008, 16'h0000, 3, 0, 0);
    add(0, 1, 0, 16'h0008, 16'h0008, 3, 1, 0);
    add(0, 1, 1, 16'h0008, 16'h0000, 3, 0, 0);
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rst, vecs[i].en, vecs[i].done, vecs[i].req);
      chk($sformatf("vec%0d", i), vecs[i].e_gnt, vecs[i].e_idx, vecs[i].e_valid, vecs[i].e_tmo);
    end
    step(1, 1, 0, 16'hFFFF);
    chk("rot_reset", 16'h0, 0, 0, 0);
    for (int i = 0; i < 17; i++) begin
      step(0, 1, 0, 16'hFFFF);
      chk($sformatf("rot_gnt%0d", i), 16'd1 << (i % 16), 4'(i % 16), 1, 0);
      step(0, 1, 1, 16'hFFFF);
      chk($sformatf("rot_rel%0d", i), 16'h0, 4'(i % 16), 0, 0);
      step(0, 1, 0, 16'hFFFF);
      chk($sformatf("rot_idle%0d", i), 16'h0, 4'(i % 16), 0, 0);
    end
    step(1, 1, 0, 16'h0004);
    chk("tmo_reset", 16'h0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      step(0, 1, 0, 16'h0004);
      chk($sformatf("tmo_hold%0d", i), 16'h0004, 2, 1, 0);
    end
    step(0, 1, 0, 16'h0004);
    chk("tmo_pulse", 16'h0, 2, 0, 1);
    step(0, 1, 0, 16'h0004);
    chk("tmo_clear", 16'h0, 2, 0, 0);
    step(0, 1, 0, 16'h0004);
    chk("tmo_regrant", 16'h0004, 2, 1, 0);
    for (int i = 0; i < 7; i++) begin
      step(0, 1, 0, 16'h0004);
      chk($sformatf("col_hold%0d", i), 16'h0004, 2, 1, 0);
    end
    step(0, 1, 1, 16'h0004);
    chk("col_done_wins", 16'h0, 2, 0, 0);
    step(0, 1, 0, 16'h0004);
    chk("col_idle", 16'h0, 2, 0, 0);
    step(0, 1, 0, 16'h0004);
    chk("col_regrant", 16'h0004, 2, 1, 0);
    step(1, 1, 0, 16'hFFFF);
    chk("rst_mid_grant", 16'h0, 0, 0, 0);
    step(0, 1, 0, 16'hFFFF);
    chk("rst_first_grant", 16'h0001, 0, 1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/rr_arb16.md
Name: rr_arb16

Overview:
- Round-robin arbiter sharing one resource among 16 requesters.
- Issues a one-hot grant, equivalent to a registered 4-to-16 decode of the winning index, gated by an enable.
- Sits in front of the shared datapath.
- Sequences ownership with request/done handshake and a hold timeout.

Parameters:
HOLD_MAX, 8, max cycles a grant may be held before forced release (legal range 1..255)
TMR_W, 8, width of hold timer; must satisfy 2^TMR_W > HOLD_MAX

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
en  input  1  arbiter enable; 0 = no new grants, active grant forcibly released
req  input  16  request vector, bit i = requester i
done  input  1  granted requester releases resource (sampled only in GRANT)
gnt  output  16  one-hot grant, registered; all-zero when no owner
gnt_idx  output  4  binary index of current/last owner, registered
valid  output  1  1 while gnt nonzero
tmo  output  1  one-cycle pulse when grant ended by timeout

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset value of every output: gnt=0, gnt_idx=0, valid=0, tmo=0.
- Reset clears internal state: priority pointer ptr=0, timer=0, state IDLE.
- Reset mid-grant drops gnt the next edge with no tmo pulse.
- States:
  - IDLE: no owner.
  - GRANT: owner holds resource.
  - REL: single dead cycle, gnt=0; guarantees a bubble between owners.
- IDLE -> GRANT: at an edge where en=1 and req!=0.
  - Winner = first set bit scanning ptr, ptr+1, ... 15, 0, ... ptr-1 (mod-16 wrap).
  - gnt_idx <= winner, gnt <= 1<<winner, valid <= 1, timer <= 1.
  - Latency: req sampled at edge k, gnt visible after edge k.
- IDLE with en=0 or req=0: stays IDLE, outputs hold 0 (gnt_idx keeps last value).
- GRANT, each edge, release checks in priority order:
  - en=0 -> REL.
  - done=1 -> REL.
  - req[gnt_idx]=0 (requester withdrew) -> REL.
  - timer==HOLD_MAX -> REL, tmo<=1 for exactly that one cycle.
  - otherwise timer <= timer+1, stay GRANT.
- On any entry to REL:
  - gnt<=0, valid<=0.
  - ptr <= gnt_idx+1 (4-bit wrap, 15 -> 0).
  - gnt_idx retained.
- REL -> IDLE unconditionally next edge; tmo cleared.
- Bubble consequence: back-to-back owners spaced by exactly 2 gnt-low cycles minimum (REL, then IDLE decision cycle).
- Simultaneous done and timeout at the same edge: done wins, tmo stays 0.
- Fairness: a continuously requesting requester waits at most 15 other grants.
- gnt is always one-hot or zero; never multi-hot, including through reset.

Test Plan:
- Reset: rst=1 two cycles with req=16'hFFFF, en=1 -> gnt=0, valid=0, gnt_idx=0, tmo=0 throughout; after release, first grant is idx 0 (gnt=16'h0001).
- Rotation: en=1, req=16'hFFFF, done pulsed 1 cycle after each grant -> gnt sequence 0001, 0002, 0004, ... 8000, 0001 (wraps 15 -> 0), each separated by 2 gnt-low cycles.
- Sparse priority: ptr=0, req=16'h8010 -> grant idx 4 (gnt=0010); after done, grant idx 15 (8000); after done, grant idx 4 again.
- Timeout: HOLD_MAX=8, req=16'h0004 held, done=0 -> gnt=0004 for exactly 8 cycles, then tmo=1 one cycle while gnt=0, then regrant idx 2 after bubble.
- Disable/withdraw: en dropped mid-grant of idx 3 -> gnt=0 next edge, no regrant while en=0. Separately, req[3] dropped mid-grant -> gnt=0 next edge, ptr=4.
- Done vs timeout collision: done=1 on the HOLD_MAX cycle -> release with tmo=0; reset asserted mid-grant -> gnt=0 next edge, next grant starts search at idx 0.
